// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and address helpers
// for the 4x4 systolic array sequencer.
package systolic_pkg;

  localparam int N         = 4;
  localparam int DW        = 4;
  localparam int CW        = 8;
  localparam int DRAIN_LEN = 2;
  localparam int FEED_LEN  = 3*N-2;

  localparam logic [3:0] FEED_LAST  = 4'(FEED_LEN-1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_LEN-1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [1:0] addr_row(input logic [3:0] a);
    return a[3:2];
  endfunction

  function automatic logic [1:0] addr_col(input logic [3:0] a);
    return a[1:0];
  endfunction

endpackage

// File: rtl/systolic_skew_feed.sv
// Registered, zero-padded skewed wavefronts for the west (A)
// and north (B) edges of the array.
module systolic_skew_feed
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        step,
  input  logic [N*N*DW-1:0] a_mem,
  input  logic [N*N*DW-1:0] b_mem,
  output logic [N*DW-1:0]   a_feed,
  output logic [N*DW-1:0]   b_feed
);

  logic [N*DW-1:0] a_nxt;
  logic [N*DW-1:0] b_nxt;
  logic [1:0]      r;
  logic [1:0]      c;

  // Element (r,c) is on the wavefront at step r+c, for both matrices.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    r     = '0;
    c     = '0;
    for (int e = 0; e < N*N; e++) begin
      r = addr_row(4'(e));
      c = addr_col(4'(e));
      if (en && (4'(r) + 4'(c) == step)) begin
        a_nxt[r*DW +: DW] = a_mem[e*DW +: DW];
        b_nxt[c*DW +: DW] = b_mem[e*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_feed <= '0;
      b_feed <= '0;
    end else begin
      a_feed <= a_nxt;
      b_feed <= b_nxt;
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the 4x4 Booth-PE systolic array: operand storage,
// clear/feed/drain FSM, result capture and readback.
module systolic_ctrl
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic              ld_sel,
  input  logic [3:0]        ld_addr,
  input  logic [DW-1:0]     ld_data,
  output logic              ld_err,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              arr_reset,
  output logic [DW-1:0]     A0,
  output logic [DW-1:0]     A1,
  output logic [DW-1:0]     A2,
  output logic [DW-1:0]     A3,
  output logic [DW-1:0]     B0,
  output logic [DW-1:0]     B1,
  output logic [DW-1:0]     B2,
  output logic [DW-1:0]     B3,
  input  logic [16*CW-1:0]  c_flat,
  input  logic [3:0]        rd_addr,
  output logic [CW-1:0]     rd_data
);

  state_t state, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [N*N*DW-1:0] a_mem, b_mem;
  logic [N*N*CW-1:0] res;
  logic [N*DW-1:0]   a_feed, b_feed;
  logic              we;
  logic              capture;

  assign busy      = (state == CLEAR) || (state == FEED) ||
                     (state == DRAIN);
  assign done      = (state == DONE);
  assign arr_reset = (state == CLEAR);
  assign we        = ld_valid && !busy;
  assign capture   = (state == DRAIN) && (nxt == DONE);

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE, DONE: if (start) nxt = CLEAR;
      CLEAR: begin
        nxt     = FEED;
        cnt_nxt = '0;
      end
      FEED:
        if (cnt == FEED_LAST) begin
          nxt     = DRAIN;
          cnt_nxt = '0;
        end else cnt_nxt = cnt + 4'd1;
      DRAIN:
        if (cnt == DRAIN_LAST) begin
          nxt     = DONE;
          cnt_nxt = '0;
        end else cnt_nxt = cnt + 4'd1;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ld_err <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      ld_err <= ld_valid && busy;
    end
  end

  // A write coincident with start lands here before the first feed step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_mem <= '0;
      b_mem <= '0;
    end else if (we) begin
      if (ld_sel) b_mem[ld_addr*DW +: DW] <= ld_data;
      else        a_mem[ld_addr*DW +: DW] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        res <= '0;
    else if (capture) res <= c_flat;
  end

  assign rd_data = res[rd_addr*CW +: CW];

  systolic_skew_feed u_feed (
    .clk    (clk),
    .reset  (reset),
    .en     (nxt == FEED),
    .step   (cnt_nxt),
    .a_mem  (a_mem),
    .b_mem  (b_mem),
    .a_feed (a_feed),
    .b_feed (b_feed)
  );

  assign A0 = a_feed[0*DW +: DW];
  assign A1 = a_feed[1*DW +: DW];
  assign A2 = a_feed[2*DW +: DW];
  assign A3 = a_feed[3*DW +: DW];
  assign B0 = b_feed[0*DW +: DW];
  assign B1 = b_feed[1*DW +: DW];
  assign B2 = b_feed[2*DW +: DW];
  assign B3 = b_feed[3*DW +: DW];

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl with a behavioural 4x4 PE array
// and a matrix-product scoreboard.
module tb_systolic_ctrl;

  logic        clk = 0;
  logic        reset;
  logic        ld_valid, ld_sel, start;
  logic [3:0]  ld_addr, ld_data, rd_addr;
  logic        ld_err, busy, done, arr_reset;
  logic [3:0]  A0, A1, A2, A3, B0, B1, B2, B3;
  logic [127:0] c_flat;
  logic [7:0]  rd_data;

  int total = 0;
  int bad   = 0;

  logic [3:0] ma [4][4];
  logic [3:0] mb [4][4];
  logic [7:0] last_c [16];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  systolic_ctrl dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_err(ld_err), .start(start),
    .busy(busy), .done(done), .arr_reset(arr_reset),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3),
    .c_flat(c_flat), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Behavioural array: operands march east/south, PEs accumulate every cycle.
  logic [3:0] fa [4];
  logic [3:0] fb [4];
  logic [3:0] ph [16];
  logic [3:0] pv [16];
  logic [7:0] acc [16];

  assign fa[0] = A0;
  assign fa[1] = A1;
  assign fa[2] = A2;
  assign fa[3] = A3;
  assign fb[0] = B0;
  assign fb[1] = B1;
  assign fb[2] = B2;
  assign fb[3] = B3;

  function automatic logic [7:0] sx(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

  function automatic logic [3:0] pe_a(input int i, input int j);
    return (j == 0) ? fa[i] : ph[i*4+j-1];
  endfunction

  function automatic logic [3:0] pe_b(input int i, input int j);
    return (i == 0) ? fb[j] : pv[(i-1)*4+j];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || arr_reset) begin
      for (int p = 0; p < 16; p++) begin
        ph[p]  <= '0;
        pv[p]  <= '0;
        acc[p] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ph[i*4+j]  <= pe_a(i, j);
          pv[i*4+j]  <= pe_b(i, j);
          acc[i*4+j] <= acc[i*4+j] +
                        sx(pe_a(i, j)) * sx(pe_b(i, j));
        end
    end
  end

  always_comb begin
    c_flat = '0;
    for (int p = 0; p < 16; p++) c_flat[p*8 +: 8] = acc[p];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push_expected();
    logic [7:0] s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = '0;
        for (int k = 0; k < 4; k++)
          s = s + sx(ma[r][k]) * sx(mb[k][c]);
        exp_q.push_back(s);
      end
  endtask

  task automatic load(input logic sel, input int r, input int c,
                      input logic [3:0] v);
    @(negedge clk);
    ld_valid = 1;
    ld_sel   = sel;
    ld_addr  = 4'(r*4+c);
    ld_data  = v;
    if (sel) mb[r][c] = v;
    else     ma[r][c] = v;
    @(negedge clk);
    ld_valid = 0;
  endtask

  // kind: 0 identity/ramp, 1 const a/b, 2 random
  task automatic load_all(input int kind, input logic [3:0] k);
    logic [3:0] va, vb;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        case (kind)
          0: begin
            va = (r == c) ? 4'd1 : 4'd0;
            vb = 4'(r*4+c-8);
          end
          1: begin va = k; vb = k; end
          default: begin
            va = 4'($urandom_range(0, 15));
            vb = 4'($urandom_range(0, 15));
          end
        endcase
        load(0, r, c, va);
        load(1, r, c, vb);
      end
  endtask

  task automatic run(input bit inj, input bit ls,
                     input logic [3:0] ls_addr,
                     input logic [3:0] ls_val);
    int cyc, nrst, nerr;
    bit seen, from_done;
    @(negedge clk);
    from_done = done;
    start = 1;
    if (ls) begin
      ld_valid = 1;
      ld_sel   = 0;
      ld_addr  = ls_addr;
      ld_data  = ls_val;
      ma[ls_addr[3:2]][ls_addr[1:0]] = ls_val;
    end
    push_expected();
    @(posedge clk);
    #1;
    start    = 0;
    ld_valid = 0;
    cyc = 0; nrst = 0; nerr = 0; seen = 0;
    while (!seen && cyc <= 40) begin
      if (arr_reset) nrst++;
      if (ld_err) nerr++;
      if (cyc == 0 && from_done) chk("done_drop", done, 0);
      if (cyc == 2) begin
        rd_addr = 4'd0;
        #1;
        chk("held_buf", rd_data, last_c[0]);
      end
      if (inj && cyc == 4) begin
        ld_valid = 1;
        ld_sel   = 0;
        ld_addr  = 4'hF;
        ld_data  = ma[3][3] ^ 4'h5;
        start    = 1;
      end
      if (inj && cyc == 5) begin
        ld_valid = 0;
        start    = 0;
      end
      if (done) seen = 1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    chk("latency", cyc, 13);
    chk("arr_rst_len", nrst, 1);
    chk("ld_err_cnt", nerr, inj ? 1 : 0);
    chk("busy_done", busy, 0);
    for (int p = 0; p < 16; p++) begin
      rd_addr = 4'(p);
      #1;
      if (exp_q.size() > 0) begin
        last_c[p] = exp_q.pop_front();
        chk($sformatf("c%0d", p), rd_data, last_c[p]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; ld_valid = 0; ld_sel = 0; start = 0;
    ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
    for (int p = 0; p < 16; p++) last_c[p] = '0;
    #23;
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_arr", arr_reset, 0);
    chk("rst_lderr", ld_err, 0);
    chk("rst_ab", {A0, A1, A2, A3, B0, B1, B2, B3}, 0);
    chk("rst_rd", rd_data, 0);

    load_all(0, 0);
    run(0, 0, 0, 0);
    load_all(1, 4'd1);
    run(0, 0, 0, 0);
    load_all(1, 4'h8);
    run(0, 0, 0, 0);
    load_all(1, 4'd7);
    run(0, 0, 0, 0);

    load_all(2, 0);
    run(1, 0, 0, 0);
    run(0, 1, 4'hF, 4'h3);

    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    reset = 1;
    @(posedge clk);
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_arr", arr_reset, 0);
    chk("mr_lderr", ld_err, 0);
    chk("mr_ab", {A0, A1, A2, A3, B0, B1, B2, B3}, 0);
    for (int p = 0; p < 16; p++) begin
      rd_addr = 4'(p);
      #1;
      chk($sformatf("mr_rd%0d", p), rd_data, 0);
    end
    @(negedge clk);
    reset = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
    for (int p = 0; p < 16; p++) last_c[p] = '0;

    load_all(2, 0);
    run(0, 0, 0, 0);
    run(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
